// File: rtl/czreg_pkg.sv
// czreg_pkg: opcodes, sequencer state encodings and default scratchpad width
package czreg_pkg;
    localparam int SPM_WIDTH_DEF = 8;
    typedef enum logic [2:0] {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC, OP_NOP} opc_t;
    typedef enum logic [2:0] {ST_IDLE, ST_RDA, ST_RDB, ST_EXE, ST_WB} state_t;
endpackage

// File: rtl/czreg_opseq_if.sv
// czreg_opseq_if: request bus and scratchpad port of the operation sequencer
interface czreg_opseq_if import czreg_pkg::*; #(parameter int SPM_WIDTH = SPM_WIDTH_DEF);
    logic                 xREQ_P, xRDY_P;
    logic [2:0]           xOPC_P;
    logic [SPM_WIDTH-1:0] xSRCA_P, xSRCB_P, xDST_P;
    logic [SPM_WIDTH-1:0] xREGRA_P, xREGWA_P;
    logic                 xREGWE_P;
    logic [7:0]           xREGDI_P, xREGDO_P;
    logic                 xDONE_P;
    logic [7:0]           xRES_P;
    logic                 xCY_P, xZ_P;
    modport master (output xREQ_P, xOPC_P, xSRCA_P, xSRCB_P, xDST_P, xREGDO_P,
                    input xRDY_P, xREGRA_P, xREGWA_P, xREGWE_P, xREGDI_P, xDONE_P, xRES_P, xCY_P, xZ_P);
    modport slave  (input xREQ_P, xOPC_P, xSRCA_P, xSRCB_P, xDST_P, xREGDO_P,
                    output xRDY_P, xREGRA_P, xREGWA_P, xREGWE_P, xREGDI_P, xDONE_P, xRES_P, xCY_P, xZ_P);
endinterface

// File: rtl/czalu.sv
// czalu: 8-bit combinational ALU, carry is carry-out for ADD/INC and borrow for SUB
module czalu import czreg_pkg::*; (
    input  opc_t       i_opc,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_res,
    output logic       o_cy
);
    logic [8:0] w_add, w_sub, w_inc;
    always_comb begin
        w_add = {1'b0, i_a} + {1'b0, i_b};
        w_sub = {1'b0, i_a} - {1'b0, i_b};
        w_inc = {1'b0, i_a} + 9'd1;
        o_res = i_opc == OP_ADD ? w_add[7:0] :
                i_opc == OP_SUB ? w_sub[7:0] :
                i_opc == OP_AND ? i_a & i_b :
                i_opc == OP_OR  ? i_a | i_b :
                i_opc == OP_XOR ? i_a ^ i_b :
                i_opc == OP_INC ? w_inc[7:0] : i_a;
        o_cy  = i_opc == OP_ADD ? w_add[8] :
                i_opc == OP_SUB ? w_sub[8] :
                i_opc == OP_INC ? w_inc[8] : 1'b0;
    end
endmodule

// File: rtl/czreg_opseq.sv
// czreg_opseq: five-cycle read-A / read-B / execute / write-back sequencer over a scratchpad
module czreg_opseq import czreg_pkg::*; #(parameter int SPM_WIDTH = SPM_WIDTH_DEF) (
    input logic          CLK,
    input logic          RST,
    czreg_opseq_if.slave bus
);
    state_t               r_state, w_next;
    opc_t                 r_opc;
    logic [SPM_WIDTH-1:0] r_srcb, r_dst, r_ra;
    logic [7:0]           r_a, r_di, r_res, w_alu_res;
    logic                 r_we, r_cy_pend, r_done, r_cy, r_z, w_alu_cy, w_rdy, w_accept;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == ST_IDLE ? (bus.xREQ_P ? ST_RDA : ST_IDLE) :
                 r_state == ST_RDA  ? ST_RDB :
                 r_state == ST_RDB  ? ST_EXE :
                 r_state == ST_EXE  ? ST_WB  : ST_IDLE;
    end

    always_comb begin
        w_rdy    = r_state == ST_IDLE;
        w_accept = w_rdy && bus.xREQ_P;
    end

    // operand B is taken straight from the scratchpad in EXE, so it needs no register
    czalu u_alu (.i_opc(r_opc), .i_a(r_a), .i_b(bus.xREGDO_P), .o_res(w_alu_res), .o_cy(w_alu_cy));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_opc     <= OP_MOV;
            r_srcb    <= '0;
            r_dst     <= '0;
            r_ra      <= '0;
            r_a       <= '0;
            r_di      <= '0;
            r_we      <= 1'b0;
            r_cy_pend <= 1'b0;
            r_done    <= 1'b0;
            r_res     <= '0;
            r_cy      <= 1'b0;
            r_z       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_opc  <= opc_t'(bus.xOPC_P);
                r_srcb <= bus.xSRCB_P;
                r_dst  <= bus.xDST_P;
                r_ra   <= bus.xSRCA_P;
            end
            if (r_state == ST_RDA) r_ra <= r_srcb;
            if (r_state == ST_RDB) r_a <= bus.xREGDO_P;
            if (r_state == ST_EXE) begin
                r_di      <= w_alu_res;
                r_cy_pend <= w_alu_cy;
                r_we      <= r_opc != OP_NOP;
            end
            if (r_state == ST_WB) begin
                r_we   <= 1'b0;
                r_done <= 1'b1;
                r_res  <= r_di;
                r_cy   <= r_cy_pend;
                r_z    <= r_di == 8'h00;
            end
        end
    end

    assign bus.xRDY_P   = w_rdy;
    assign bus.xREGRA_P = r_ra;
    assign bus.xREGWA_P = r_dst;
    assign bus.xREGWE_P = r_we;
    assign bus.xREGDI_P = r_di;
    assign bus.xDONE_P  = r_done;
    assign bus.xRES_P   = r_res;
    assign bus.xCY_P    = r_cy;
    assign bus.xZ_P     = r_z;
endmodule
